operand_fetch: RTL

//  Upstream operand stage for the 16-bit ALU: 8-entry register file, A/B operand

---
 rtl/operand_fetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Operand stage for the 16-bit ALU: register file, two-cycle A/B fetch with
// write-back bypass, B-path shifter and source muxes, valid/ready handoff.
module operand_fetch #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [1:0]        shift,
  input  logic              asel,
  input  logic              bsel,
  input  logic [WIDTH-1:0]  sximm5,
  input  logic [1:0]        aluop_in,
  output logic              busy,
  output logic              valid,
  input  logic              ready,
  output logic [WIDTH-1:0]  Ain,
  output logic [WIDTH-1:0]  Bin,
  output logic [1:0]        aluop_out,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_num,
  input  logic [WIDTH-1:0]  wb_data
);

  localparam int unsigned NREGS = 1 << REG_AW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    VALID  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]  regs [NREGS];
  logic [WIDTH-1:0]  a_q;
  logic [REG_AW-1:0] rn_l, rm_l;
  logic [1:0]        shift_l, aluop_l;
  logic              asel_l, bsel_l;
  logic [WIDTH-1:0]  sximm5_l;

  logic [WIDTH-1:0]  rd_a_c, rd_b_c, shifted_c;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ_A;
      READ_A:  state_d = READ_B;
      READ_B:  state_d = VALID;
      VALID:   if (ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register reads see a same-cycle write-back to the register being read
  always_comb begin
    rd_a_c = regs[rn_l];
    rd_b_c = regs[rm_l];
    if (wb_en && (wb_num == rn_l)) rd_a_c = wb_data;
    if (wb_en && (wb_num == rm_l)) rd_b_c = wb_data;
  end

  always_comb begin
    shifted_c = rd_b_c;
    case (shift_l)
      2'b01:   shifted_c = {rd_b_c[WIDTH-2:0], 1'b0};
      2'b10:   shifted_c = {1'b0, rd_b_c[WIDTH-1:1]};
      2'b11:   shifted_c = {rd_b_c[WIDTH-1], rd_b_c[WIDTH-1:1]};
      default: shifted_c = rd_b_c;
    endcase
  end

  // Register file: written in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_num] <= wb_data;
    end
  end

  // Outputs load only on entry to VALID, so they hold across backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      valid     <= 1'b0;
      a_q       <= '0;
      rn_l      <= '0;
      rm_l      <= '0;
      shift_l   <= '0;
      aluop_l   <= '0;
      asel_l    <= 1'b0;
      bsel_l    <= 1'b0;
      sximm5_l  <= '0;
      Ain       <= '0;
      Bin       <= '0;
      aluop_out <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      valid   <= (state_d == VALID);
      if ((state_q == IDLE) && start) begin
        rn_l     <= rn;
        rm_l     <= rm;
        shift_l  <= shift;
        aluop_l  <= aluop_in;
        asel_l   <= asel;
        bsel_l   <= bsel;
        sximm5_l <= sximm5;
      end
      if (state_q == READ_A) a_q <= rd_a_c;
      if (state_q == READ_B) begin
        Ain       <= asel_l ? '0 : a_q;
        Bin       <= bsel_l ? sximm5_l : shifted_c;
        aluop_out <= aluop_l;
      end
    end
  end

endmodule
